// File: rtl/reg_wb_sched.sv
// Write-back scheduler: merges ALU, load and divide results onto the register-file dst port
// and tracks registers with outstanding load/divide writes. Optional macro: WB_FWD_EN.
module reg_wb_sched #(
  parameter int LD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic        alu_we,
  input  logic [5:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [5:0]  ld_reg,
  input  logic [31:0] ld_data,
  input  logic        div_valid,
  input  logic [5:0]  div_reg,
  input  logic [31:0] div_data,
  input  logic        sb_set,
  input  logic [5:0]  sb_reg,
  input  logic        qsrc_en,
  input  logic [5:0]  qsrc,
  input  logic        qdst_en,
  input  logic [5:0]  qdst,
  output logic [5:0]  dsta,
  output logic [31:0] dstwd,
  output logic        dstrwen_n,
  output logic        stall,
  output logic        ld_full,
  output logic        div_busy,
  output logic        ld_ovf
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [5:0]    r_ld_reg  [LD_DEPTH];
  logic [31:0]   r_ld_data [LD_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_div_vld;
  logic [5:0]    r_div_reg;
  logic [31:0]   r_div_data;
  logic [63:0]   r_sb;

  logic          w_fifo_ne;
  logic          w_sel_fifo;
  logic          w_sel_lddir;
  logic          w_ld_sel;
  logic          w_sel_hold;
  logic          w_sel_divdir;
  logic          w_push;
  logic          w_pop;
  logic          w_hold_load;
  logic          w_wr_en;
  logic [5:0]    w_wr_reg;
  logic [31:0]   w_wr_data;
  logic          w_pend_sel;
  logic [5:0]    w_pend_reg;
  logic [63:0]   w_sb_next;
  logic          w_src_fwd;
  logic          w_dst_fwd;

  // ALU always wins; loads come from the FIFO head first so ordering is kept.
  assign w_fifo_ne    = (r_count != '0);
  assign w_sel_fifo   = !alu_we && w_fifo_ne;
  assign w_sel_lddir  = !alu_we && !w_fifo_ne && ld_valid;
  assign w_ld_sel     = w_sel_fifo || w_sel_lddir;
  assign w_sel_hold   = !alu_we && !w_ld_sel && r_div_vld;
  assign w_sel_divdir = !alu_we && !w_ld_sel && !r_div_vld && div_valid;
  assign w_push       = ld_valid && !ld_full && !w_sel_lddir;
  assign w_pop        = w_sel_fifo;
  assign w_hold_load  = div_valid && !r_div_vld && !w_sel_divdir;

  assign ld_full  = (r_count == CW'(LD_DEPTH));
  assign div_busy = r_div_vld;
  assign ld_ovf   = r_ovf;

  always_comb begin
    w_wr_en    = 1'b1;
    w_wr_reg   = alu_reg;
    w_wr_data  = alu_data;
    w_pend_sel = 1'b1;
    w_pend_reg = alu_reg;
    if (alu_we) begin
      w_pend_sel = 1'b0;
    end else if (w_sel_fifo) begin
      w_wr_reg  = r_ld_reg[r_rd_ptr];
      w_wr_data = r_ld_data[r_rd_ptr];
    end else if (w_sel_lddir) begin
      w_wr_reg  = ld_reg;
      w_wr_data = ld_data;
    end else if (w_sel_hold) begin
      w_wr_reg  = r_div_reg;
      w_wr_data = r_div_data;
    end else if (w_sel_divdir) begin
      w_wr_reg  = div_reg;
      w_wr_data = div_data;
    end else begin
      w_wr_en    = 1'b0;
      w_pend_sel = 1'b0;
    end
    if (w_wr_en && !alu_we) w_pend_reg = w_wr_reg;
  end

  // A new launch to the same register must survive the retiring write.
  always_comb begin
    w_sb_next = r_sb;
    if (w_pend_sel) w_sb_next[w_pend_reg] = 1'b0;
    if (sb_set) w_sb_next[sb_reg] = 1'b1;
  end

`ifdef WB_FWD_EN
  assign w_src_fwd = w_pend_sel && (w_pend_reg == qsrc);
  assign w_dst_fwd = w_pend_sel && (w_pend_reg == qdst);
`else
  assign w_src_fwd = 1'b0;
  assign w_dst_fwd = 1'b0;
`endif

  assign stall = (qsrc_en && r_sb[qsrc] && !w_src_fwd) ||
                 (qdst_en && r_sb[qdst] && !w_dst_fwd);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ld_reg[r_wr_ptr]  <= ld_reg;
      r_ld_data[r_wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_div_vld  <= 1'b0;
      r_div_reg  <= '0;
      r_div_data <= '0;
      r_sb       <= '0;
      dsta       <= '0;
      dstwd      <= '0;
      dstrwen_n  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (ld_valid && ld_full) r_ovf <= 1'b1;
      if (w_sel_hold)       r_div_vld <= 1'b0;
      else if (w_hold_load) r_div_vld <= 1'b1;
      if (w_hold_load) begin
        r_div_reg  <= div_reg;
        r_div_data <= div_data;
      end
      r_sb      <= w_sb_next;
      dstrwen_n <= !w_wr_en;
      if (w_wr_en) begin
        dsta  <= w_wr_reg;
        dstwd <= w_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_sched.sv
// Scoreboard bench for reg_wb_sched: queue-based reference model predicts each cycle's
// register-file write; a negedge monitor pops and compares. Honours WB_FWD_EN in the model.
module tb_reg_wb_sched;

  localparam int LD_DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetl = 1'b0;
  logic        alu_we, ld_valid, div_valid, sb_set, qsrc_en, qdst_en;
  logic [5:0]  alu_reg, ld_reg, div_reg, sb_reg, qsrc, qdst;
  logic [31:0] alu_data, ld_data, div_data;
  logic [5:0]  dsta;
  logic [31:0] dstwd;
  logic        dstrwen_n, stall, ld_full, div_busy, ld_ovf;

  reg_wb_sched #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .resetl(resetl),
    .alu_we(alu_we), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data),
    .div_valid(div_valid), .div_reg(div_reg), .div_data(div_data),
    .sb_set(sb_set), .sb_reg(sb_reg),
    .qsrc_en(qsrc_en), .qsrc(qsrc), .qdst_en(qdst_en), .qdst(qdst),
    .dsta(dsta), .dstwd(dstwd), .dstrwen_n(dstrwen_n),
    .stall(stall), .ld_full(ld_full), .div_busy(div_busy), .ld_ovf(ld_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        aWe;  logic [5:0] aReg;  logic [31:0] aData;
    logic        lV;   logic [5:0] lReg;  logic [31:0] lData;
    logic        dV;   logic [5:0] dReg;  logic [31:0] dData;
    logic        sbS;  logic [5:0] sbR;
    logic        qsE;  logic [5:0] qs;
    logic        qdE;  logic [5:0] qd;
  } stim_t;

  typedef struct packed { logic [5:0] r; logic [31:0] d; } wr_t;
  typedef struct packed { logic we; logic [5:0] r; logic [31:0] d; } exp_t;

  wr_t  mFifo[$];
  bit   mHoldV;
  wr_t  mHold;
  bit   mSb[64];
  bit   mOvf;
  exp_t expQ[$];
  exp_t monE;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 none, 1 alu, 2 fifo head, 3 direct load, 4 div holder, 5 direct div
  function automatic int modelSel();
    if (alu_we) return 1;
    if (mFifo.size() > 0) return 2;
    if (ld_valid) return 3;
    if (mHoldV) return 4;
    if (div_valid) return 5;
    return 0;
  endfunction

  function automatic wr_t modelWrite(input int k);
    wr_t w;
    case (k)
      1: w = '{r: alu_reg, d: alu_data};
      2: w = mFifo[0];
      3: w = '{r: ld_reg, d: ld_data};
      4: w = mHold;
      5: w = '{r: div_reg, d: div_data};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic bit modelStall();
    int  k = modelSel();
    wr_t w = modelWrite(k);
    bit  s = qsrc_en && mSb[qsrc];
    bit  d = qdst_en && mSb[qdst];
`ifdef WB_FWD_EN
    if (k >= 2 && w.r == qsrc) s = 1'b0;
    if (k >= 2 && w.r == qdst) d = 1'b0;
`else
    if (w.r == 6'd0 && k < 0) s = 1'b0;
`endif
    return s || d;
  endfunction

  task automatic modelStep();
    int  k = modelSel();
    wr_t w = modelWrite(k);
    bit  fullBefore = (mFifo.size() == LD_DEPTH);
    bit  holdBefore = mHoldV;
    if (k == 2) void'(mFifo.pop_front());
    if (ld_valid && k != 3) begin
      if (fullBefore) mOvf = 1'b1;
      else mFifo.push_back('{r: ld_reg, d: ld_data});
    end
    if (k == 4) mHoldV = 1'b0;
    if (div_valid && k != 5 && !holdBefore) begin
      mHoldV = 1'b1;
      mHold  = '{r: div_reg, d: div_data};
    end
    if (k >= 2) mSb[w.r] = 1'b0;
    if (sb_set) mSb[sb_reg] = 1'b1;
    expQ.push_back('{we: (k != 0), r: w.r, d: w.d});
  endtask

  task automatic driveInputs(input stim_t s);
    alu_we = s.aWe;    alu_reg = s.aReg;  alu_data = s.aData;
    ld_valid = s.lV;   ld_reg = s.lReg;   ld_data = s.lData;
    div_valid = s.dV;  div_reg = s.dReg;  div_data = s.dData;
    sb_set = s.sbS;    sb_reg = s.sbR;
    qsrc_en = s.qsE;   qsrc = s.qs;
    qdst_en = s.qdE;   qdst = s.qd;
  endtask

  task automatic checkOutput();
    check("ld_full", 64'(ld_full), 64'(mFifo.size() == LD_DEPTH));
    check("div_busy", 64'(div_busy), 64'(mHoldV));
    check("ld_ovf", 64'(ld_ovf), 64'(mOvf));
    check("stall", 64'(stall), 64'(modelStall()));
  endtask

  task automatic applyStimulus(input stim_t sIn);
    stim_t s = sIn;
    @(posedge clk);
    if (resetl) modelStep();
    #1;
    if (mHoldV) s.dV = 1'b0;
    driveInputs(s);
    #1;
    checkOutput();
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    if (resetl) modelStep();
    #1;
    resetl = 1'b0;
    driveInputs('0);
    mFifo.delete();
    expQ.delete();
    mHoldV = 1'b0;
    mOvf = 1'b0;
    foreach (mSb[i]) mSb[i] = 1'b0;
    #1;
    check("rst_wen", 64'(dstrwen_n), 64'(1));
    check("rst_dsta", 64'(dsta), 64'(0));
    check("rst_dstwd", 64'(dstwd), 64'(0));
    checkOutput();
    repeat (n) @(posedge clk);
    #1;
    resetl = 1'b1;
    #1;
    checkOutput();
  endtask

  // Monitor: one expected entry per clock edge after reset release.
  always @(negedge clk) begin
    if (resetl === 1'b1) begin
      if (expQ.size() > 0) begin
        monE = expQ.pop_front();
        check("wen", 64'(dstrwen_n), 64'(!monE.we));
        if (monE.we) begin
          check("dsta", 64'(dsta), 64'(monE.r));
          check("dstwd", 64'(dstwd), 64'(monE.d));
        end
      end else begin
        check("idle_wen", 64'(dstrwen_n), 64'(1));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    driveInputs('0);
    foreach (mSb[i]) mSb[i] = 1'b0;
    doReset(2);

    s = '0; s.lV = 1'b1; s.lReg = 6'd5; s.lData = 32'h1234;
    applyStimulus(s);
    applyStimulus('0);
    applyStimulus('0);

    s = '0; s.aWe = 1'b1; s.aReg = 6'd3; s.aData = 32'hA3A3;
    s.lV = 1'b1; s.lReg = 6'd7; s.lData = 32'h0707;
    applyStimulus(s);
    applyStimulus('0);
    applyStimulus('0);
    applyStimulus('0);

    for (int i = 0; i < 5; i++) begin
      s = '0; s.aWe = 1'b1; s.aReg = 6'(20 + i); s.aData = 32'(100 + i);
      s.lV = 1'b1; s.lReg = 6'(40 + i); s.lData = 32'(200 + i);
      applyStimulus(s);
    end
    repeat (7) applyStimulus('0);

    s = '0; s.sbS = 1'b1; s.sbR = 6'd9;
    applyStimulus(s);
    s = '0; s.qsE = 1'b1; s.qs = 6'd9;
    repeat (3) applyStimulus(s);
    s.lV = 1'b1; s.lReg = 6'd9; s.lData = 32'h9999;
    applyStimulus(s);
    s.lV = 1'b0;
    repeat (2) applyStimulus(s);

    s = '0; s.aWe = 1'b1; s.aReg = 6'd1; s.aData = 32'h11;
    s.dV = 1'b1; s.dReg = 6'd2; s.dData = 32'h2222;
    applyStimulus(s);
    s.dV = 1'b0;
    applyStimulus(s);
    doReset(1);
    repeat (3) applyStimulus('0);

    s = '0; s.lV = 1'b1; s.lReg = 6'd4; s.lData = 32'h4444; s.sbS = 1'b1; s.sbR = 6'd4;
    applyStimulus(s);
    s = '0; s.qsE = 1'b1; s.qs = 6'd4;
    repeat (2) applyStimulus(s);

    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.aWe   = ($urandom_range(0, 9) < 4);
      s.aReg  = 6'($urandom_range(0, 63));
      s.aData = $urandom;
      s.lV    = ($urandom_range(0, 9) < 4);
      s.lReg  = 6'($urandom_range(0, 15));
      s.lData = $urandom;
      s.dV    = ($urandom_range(0, 9) < 2);
      s.dReg  = 6'($urandom_range(0, 15));
      s.dData = $urandom;
      s.sbS   = ($urandom_range(0, 9) < 3);
      s.sbR   = 6'($urandom_range(0, 15));
      s.qsE   = ($urandom_range(0, 1) == 1);
      s.qs    = 6'($urandom_range(0, 15));
      s.qdE   = ($urandom_range(0, 1) == 1);
      s.qd    = 6'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) doReset(1);
      else applyStimulus(s);
    end

    repeat (10) applyStimulus('0);
    @(negedge clk);
    #1;
    check("drain", 64'(expQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
